// File: rtl/handshake_fifo_pkg.sv
// Shared elaboration helpers for the handshake FIFO slice.
// Keeps parameter legality checks in one place for the top and its storage.
package handshake_fifo_pkg;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int depth, input int addr_width);
        return is_pow2(depth) && (depth >= 4) && (addr_width == $clog2(depth));
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for handshake_fifo: one synchronous write port, one
// combinational read port addressed by the read pointer.
module handshake_fifo_mem #(
    parameter int data_width = 32,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [depth];

    // NOTE: storage is deliberately left out of reset; occupancy and pointers
    // decide what is valid, so clearing every entry would only cost logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer between a stalling upstream source and a dataflow
// array input. Requests upstream while a slot is spare, acks downstream one word per pulse.
module handshake_fifo
    import handshake_fifo_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  up_req,
    input  logic                  up_ack,
    input  logic [data_width-1:0] up_din,
    input  logic                  dn_req,
    output logic                  dn_ack,
    output logic [data_width-1:0] dn_dout,
    output logic [addr_width:0]   count,
    output logic                  overflow
);

    if (!params_legal(depth, addr_width)) begin : g_param_check
        $error("handshake_fifo: depth must be a power of 2 >= 4 and addr_width == clog2(depth)");
    end

    localparam logic [addr_width:0] full_level = (addr_width + 1)'(depth);
    // One slot is held back for an ack that may already be in flight.
    localparam logic [addr_width:0] req_level  = (addr_width + 1)'(depth - 2);

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   count_next;
    logic [data_width-1:0] rd_data;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;

    assign full  = (count == full_level);
    assign wr_en = rst && up_ack && !full;
    assign rd_en = rst && dn_req && !dn_ack && (count != '0);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_next = count - 1'b1;
        end
    end

    handshake_fifo_mem #(
        .data_width(data_width),
        .depth     (depth),
        .addr_width(addr_width)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(up_din),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            up_req   <= 1'b0;
            dn_ack   <= 1'b0;
            dn_dout  <= '0;
            overflow <= 1'b0;
        end else begin
            count  <= count_next;
            up_req <= (count_next <= req_level);
            dn_ack <= rd_en;
            // Pointers wrap for free because depth is a power of 2.
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                dn_dout <= rd_data;
            end
            if (up_ack && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
